// File: rtl/timer_ctrl.sv
// timer_ctrl: memory-mapped compare timer with one-shot and auto-reload modes.
// A WIDTH-bit up-counter advances on tick_en while running and raises a level
// interrupt when it matches the compare register.
module timer_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_en,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_addr,
   input  logic [WIDTH-1:0] cfg_wdata,
   output logic [WIDTH-1:0] cfg_rdata,
   output logic             irq,
   output logic             running
);

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_CMP    = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] cmp_q, cmp_d;
   logic             en_q, en_d;
   logic             auto_q, auto_d;
   logic             ie_q, ie_d;
   logic             expired_q, expired_d;
   logic             irq_q;
   logic             running_q;

   logic             tick_run;
   logic             match;
   logic             set_exp;
   logic             clr_exp;

   // Next-state: tick processing first, then register writes override it.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      cmp_d     = cmp_q;
      en_d      = en_q;
      auto_d    = auto_q;
      ie_d      = ie_q;
      expired_d = expired_q;

      tick_run = (state_q == S_RUN) && tick_en;
      match    = (count_q == cmp_q);
      set_exp  = tick_run && match;
      clr_exp  = cfg_we && (cfg_addr == ADDR_STATUS) && cfg_wdata[0];

      // Compare always sees the pre-write cmp and pre-increment count.
      if (tick_run) begin
         if (match) begin
            if (auto_q) begin
               count_d = '0;
            end else begin
               state_d = S_HALT;
               en_d    = 1'b0;
            end
         end else begin
            count_d = count_q + WIDTH'(1);
         end
      end

      // A new expiry beats a simultaneous write-1-to-clear.
      if (set_exp) begin
         expired_d = 1'b1;
      end else if (clr_exp) begin
         expired_d = 1'b0;
      end

      if (cfg_we) begin
         case (cfg_addr)
            ADDR_CTRL: begin
               en_d   = cfg_wdata[0];
               auto_d = cfg_wdata[1];
               ie_d   = cfg_wdata[2];
               if (!cfg_wdata[0]) begin
                  state_d = S_IDLE;
                  count_d = count_q;
               end else if (state_q == S_HALT) begin
                  state_d = S_RUN;
                  count_d = '0;
               end else begin
                  state_d = S_RUN;
               end
            end
            ADDR_CMP:   cmp_d   = cfg_wdata;
            ADDR_COUNT: count_d = cfg_wdata;
            default: ;
         endcase
      end
   end

   // State and register update with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         cmp_q     <= '0;
         en_q      <= 1'b0;
         auto_q    <= 1'b0;
         ie_q      <= 1'b0;
         expired_q <= 1'b0;
         irq_q     <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         cmp_q     <= cmp_d;
         en_q      <= en_d;
         auto_q    <= auto_d;
         ie_q      <= ie_d;
         expired_q <= expired_d;
         irq_q     <= expired_d & ie_d;
         running_q <= (state_d == S_RUN);
      end
   end

   // Zero-latency register readback.
   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         ADDR_CTRL:   cfg_rdata = WIDTH'({ie_q, auto_q, en_q});
         ADDR_CMP:    cfg_rdata = cmp_q;
         ADDR_COUNT:  cfg_rdata = count_q;
         ADDR_STATUS: cfg_rdata = WIDTH'(expired_q);
         default:     cfg_rdata = '0;
      endcase
   end

   assign irq     = irq_q;
   assign running = running_q;

endmodule
